// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- data-memory controller for the xgriscv MEM stage.
//
// It replaces the always-ready data RAM with a request/response handshake and
// a programmable wait-state counter. It handles byte, half and word
// loads/stores, sign/zero-extends load data, and flags misaligned,
// out-of-range and illegal-size accesses.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its payload stable while valid is high. The
// consumer may drive ready regardless of valid.
//
// Parameters:
//   XLEN        data/address width (only 32 is supported)
//   DEPTH       number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES extra cycles between acceptance and memory access (0..15)
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   req_valid/ready     request handshake
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        zero-extend loads (lbu/lhu)
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   resp_valid/ready    response handshake
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            access fault
//   err_count           saturating fault counter (needs DMEM_ERRCNT_EN, else 0)
//   dbg_state           current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Optional feature macro: DMEM_ERRCNT_EN enables the err_count counter.

module dmem_ctrl #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [15:0]     err_count,
  output logic [1:0]      dbg_state
);

  localparam int AW = $clog2(DEPTH);
  // The counter holds the remaining wait cycles minus one, so the access
  // happens on the edge where it reads zero.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            accept;
  logic            access;

  // Request latched at acceptance.
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;

  logic [XLEN-1:0] resp_rdata_q;
  logic            resp_err_q;

  logic [XLEN-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            wcnt_d  = WAIT_LOAD;
            state_d = ST_WAIT;
          end else begin
            access  = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Access operands: with no wait states the access happens on the
  // acceptance edge itself, before the latches hold the request, so the
  // live request inputs are used while in IDLE.
  // ---------------------------------------------------------------------
  logic            a_we;
  logic [1:0]      a_size;
  logic            a_uns;
  logic [XLEN-1:0] a_addr;
  logic [XLEN-1:0] a_wdata;

  always_comb begin
    if (state_q == ST_IDLE) begin
      a_we    = req_we;
      a_size  = req_size;
      a_uns   = req_unsigned;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end else begin
      a_we    = we_q;
      a_size  = size_q;
      a_uns   = uns_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  logic [AW-1:0]   word_idx;
  logic [1:0]      lane;
  logic            out_of_range;
  logic            misalign;
  logic            a_err;

  assign word_idx     = a_addr[AW+1:2];
  assign lane         = a_addr[1:0];
  assign out_of_range = |a_addr[XLEN-1:AW+2];

  always_comb begin
    misalign = 1'b0;
    unique case (a_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = a_addr[0];
      2'b10:   misalign = |a_addr[1:0];
      default: misalign = 1'b1;   // illegal size is reported as a fault
    endcase
  end

  assign a_err = misalign | out_of_range;

  // Store lane enables and data replicated across the lanes.
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_sh;

  always_comb begin
    be       = 4'b0000;
    wdata_sh = a_wdata;
    unique case (a_size)
      2'b00: begin
        be       = 4'b0001 << lane;
        wdata_sh = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be       = a_addr[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{a_wdata[15:0]}};
      end
      2'b10: begin
        be       = 4'b1111;
        wdata_sh = a_wdata;
      end
      default: be = 4'b0000;
    endcase
  end

  // Load path: pick the addressed byte/half, then extend.
  logic [XLEN-1:0] rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] rdata_next;

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = a_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = '0;
    unique case (a_size)
      2'b00:   load_data = a_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = a_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      2'b10:   load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  assign rdata_next = (a_err || a_we) ? '0 : load_data;

  // ---------------------------------------------------------------------
  // State, latches and response registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= 4'd0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (access) begin
        resp_rdata_q <= rdata_next;
        resp_err_q   <= a_err;
      end
    end
  end

  // RAM write port; not reset. Reset blocks a pending write because it
  // takes priority over the access edge.
  always_ff @(posedge clk) begin
    if (!reset && access && !a_err && a_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_ERRCNT_EN
  logic [15:0] err_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= 16'h0000;
    end else if (access && a_err && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'h0001;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'h0000;
`endif

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances, WAIT_CYCLES=0 (index 0) and
// WAIT_CYCLES=3 (index 1), checked against a byte-array reference model.

module tb_dmem_ctrl;

  localparam int DEPTH = 128;
  localparam int NB    = DEPTH * 4;

  // ---------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_rdata   [2];
  logic        resp_err     [2];
  logic [15:0] err_count    [2];
  logic [1:0]  dbg_state    [2];

  dmem_ctrl #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .err_count(err_count[0]), .dbg_state(dbg_state[0])
  );

  dmem_ctrl #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .err_count(err_count[1]), .dbg_state(dbg_state[1])
  );

  // ---------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------
  logic [7:0]  ref_mem  [2][NB];
  int          ref_errs [2];
  logic [32:0] exp_q [$];   // {err, rdata}

  int n_cmp = 0;
  int n_mis = 0;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Applies an access to the byte-array model and queues the expected response.
  function automatic void model_access(input int d, input logic we, input logic [1:0] size,
                                       input logic uns, input logic [31:0] addr,
                                       input logic [31:0] wdata);
    logic   err;
    int     nbytes;
    longint v;
    logic [31:0] rd;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr >= NB);
    nbytes = 1 << size;
    rd = 32'h0;
    if (err) begin
      if (ref_errs[d] < 65535) ref_errs[d]++;
    end else if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[d][int'(addr) + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < nbytes; i++) v = v | (longint'(ref_mem[d][int'(addr) + i]) << (8 * i));
      if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v - (longint'(1) << (8 * nbytes));
      rd = v[31:0];
    end
    exp_q.push_back({err, rd});
  endfunction

  function automatic logic [15:0] exp_errcnt(input int d);
`ifdef DMEM_ERRCNT_EN
    return 16'(ref_errs[d]);
`else
    return (d == 0 || d == 1) ? 16'h0000 : 16'hFFFF;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input int d);
    check("rst_req_ready",  32'(req_ready[d]),  32'd1);
    check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
    check("rst_resp_rdata", resp_rdata[d],      32'd0);
    check("rst_resp_err",   32'(resp_err[d]),   32'd0);
    check("rst_err_count",  32'(err_count[d]),  32'd0);
    check("rst_state",      32'(dbg_state[d]),  32'd0);
  endtask

  // ---------------------------------------------------------------------
  // Driver: one full transaction. Entered and left at posedge+1, DUT idle.
  // hold = cycles resp_ready is held low once the response appears.
  // ---------------------------------------------------------------------
  task automatic do_access(input int d, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold,
                           output logic [31:0] obs_rdata, output logic obs_err);
    int          lat;
    logic [32:0] e;
    logic [31:0] held_rdata;
    logic        held_err;
    model_access(d, we, size, uns, addr, wdata);
    check("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_we[d] = we; req_size[d] = size; req_unsigned[d] = uns;
    req_addr[d] = addr; req_wdata[d] = wdata; req_valid[d] = 1'b1;
    @(posedge clk); #1;
    // Scramble the request bus: the DUT must ignore it from here on.
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_size[d] = 2'($urandom);
    req_unsigned[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(wait_of(d) + 1));
    check("req_ready_busy", 32'(req_ready[d]), 32'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
    check("resp_rdata", resp_rdata[d], e[31:0]);
    check("resp_err", 32'(resp_err[d]), 32'(e[32]));
    check("err_count", 32'(err_count[d]), 32'(exp_errcnt(d)));
    obs_rdata  = resp_rdata[d];
    obs_err    = resp_err[d];
    held_rdata = e[31:0];
    held_err   = e[32];
    if (hold > 0) begin
      resp_ready[d] = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(resp_valid[d]), 32'd1);
        check("hold_rdata", resp_rdata[d], held_rdata);
        check("hold_err", 32'(resp_err[d]), 32'(held_err));
        check("hold_req_ready", 32'(req_ready[d]), 32'd0);
      end
      resp_ready[d] = 1'b1;
    end
    @(posedge clk); #1;
    check("resp_drop", 32'(resp_valid[d]), 32'd0);
    check("req_ready_back", 32'(req_ready[d]), 32'd1);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin : main
    logic [31:0] rd;
    logic        er;
    logic [32:0] e;

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
      req_unsigned[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
      resp_ready[d] = 1'b1; ref_errs[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset[0] = 1'b0; reset[1] = 1'b0;
    check_reset_values(0);
    check_reset_values(1);

    // Clear both RAMs so every later load has a defined expectation.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++)
        do_access(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'h0, 0, rd, er);

    // Word store / load, no wait states.
    do_access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("t1_store_rdata", rd, 32'h0);
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er);
    check("t1_load_word", rd, 32'hDEADBEEF);
    check("t1_load_err", 32'(er), 32'd0);

    // Byte lanes and extension.
    do_access(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h123456AA, 0, rd, er);
    do_access(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF8001, 0, rd, er);
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, rd, er);
    check("t2_word", rd, 32'h8001AA00);
    do_access(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0, rd, er);
    check("t2_half_s", rd, 32'hFFFF8001);
    do_access(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0, rd, er);
    check("t2_half_u", rd, 32'h00008001);
    do_access(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 0, rd, er);
    check("t2_byte_s", rd, 32'hFFFFFFAA);
    do_access(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 0, rd, er);
    check("t2_byte_u", rd, 32'h000000AA);

    // Faults.
    do_access(0, 1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 0, rd, er);
    check("t3_mis_half_err", 32'(er), 32'd1);
    check("t3_mis_half_rd", rd, 32'h0);
    do_access(0, 1'b1, 2'd2, 1'b0, 32'h06, 32'h55AA55AA, 0, rd, er);
    check("t3_mis_word_err", 32'(er), 32'd1);
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0, rd, er);
    check("t3_range_err", 32'(er), 32'd1);
    check("t3_range_rd", rd, 32'h0);
`ifdef DMEM_ERRCNT_EN
    check("t3_err_count", 32'(err_count[0]), 32'd3);
`else
    check("t3_err_count", 32'(err_count[0]), 32'd0);
`endif
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 0, rd, er);
    check("t3_ram_unchanged", rd, 32'h0);
    do_access(0, 1'b0, 2'd3, 1'b0, 32'h08, 32'h0, 0, rd, er);
    check("t3_size11_err", 32'(er), 32'd1);

    // Wait states with back-pressure.
    do_access(1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hA5A51234, 0, rd, er);
    do_access(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 5, rd, er);
    check("t4_load_word", rd, 32'hA5A51234);

    // Reset aborts a store sitting in WAIT.
    do_access(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 0, rd, er);
    req_we[1] = 1'b1; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h40; req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset[1] = 1'b1;
    @(posedge clk); #1;
    reset[1] = 1'b0;
    ref_errs[1] = 0;
    check_reset_values(1);
    do_access(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, rd, er);
    check("t5_aborted_write", rd, 32'hCAFEF00D);

    // Back-to-back loads with req_valid held high.
    req_we[0] = 1'b0; req_size[0] = 2'd2; req_unsigned[0] = 1'b0; req_valid[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_addr[0] = 32'(k * 4 + 32'h10);
      model_access(0, 1'b0, 2'd2, 1'b0, req_addr[0], 32'h0);
      @(posedge clk); #1;
      check("b2b_valid", 32'(resp_valid[0]), 32'd1);
      check("b2b_req_ready", 32'(req_ready[0]), 32'd0);
      e = exp_q.pop_front();
      check("b2b_rdata", resp_rdata[0], e[31:0]);
      @(posedge clk); #1;
      check("b2b_gap", 32'(resp_valid[0]), 32'd0);
    end
    req_valid[0] = 1'b0;

    // Random traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        logic [1:0]  sz;
        logic [31:0] ad;
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        ad = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NB - 1));
        do_access(d, 1'($urandom), sz, 1'($urandom), ad, $urandom,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, rd, er);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory block for the xgriscv core. It replaces the single-cycle, always-ready data RAM with a request/response handshake and a programmable wait-state counter. It handles byte, half and word stores and loads, sign/zero-extends load data, and flags misaligned or out-of-range accesses. It sits between the MEM stage and the word-organised data array.

Parameters:
- XLEN, 32: data and address width; only 32 is supported.
- DEPTH, 128: number of 32-bit words. Must be a power of two, at least 4.
- WAIT_CYCLES, 0: extra cycles between request acceptance and memory access, range 0..15.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_unsigned  in  1  load zero-extend (lbu/lhu); ignored for stores.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned (the byte is in [7:0], the half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal-size access.
- err_count  out  16  fault counter (see Optional Feature).

Behaviour:
- Reset and clocking: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, err_count=0, wait counter 0. RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - Go to WAIT if WAIT_CYCLES>0 and load the counter with WAIT_CYCLES-1.
  - Otherwise perform the access on this edge and go to RESP.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - When the counter is 0, perform the access on that edge and go to RESP.
- Latency: resp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_valid && resp_ready.
  - On that edge go to IDLE, and drop resp_valid the next cycle.
  - req_ready=0 in RESP, so there is no overlap and accesses are strictly serialised.
  - Throughput is one access per WAIT_CYCLES+2 cycles when resp_ready is held at 1.
- Access, word index = addr[log2(DEPTH)+1:2], lane = addr[1:0], little-endian:
  - Error if size=11, size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or addr[XLEN-1:log2(DEPTH)+2] nonzero.
  - On error: no RAM write, resp_err=1, resp_rdata=0.
  - Store byte: write lane [8*lane+7:8*lane] with wdata[7:0]; other bytes unchanged.
  - Store half: write [16*addr[1]+15:16*addr[1]] with wdata[15:0].
  - Store word: write the whole word.
  - Store response: resp_err=0, resp_rdata=0.
  - Load: select the byte or half at the lane, then sign-extend (req_unsigned=0) or zero-extend (req_unsigned=1). A word load returns the whole word.
- Read data is sampled on the access edge, so a load following a store to the same word returns the updated value.
- Input changes outside IDLE acceptance are ignored.
- Reset mid-operation: reset in WAIT aborts the access and no RAM write occurs. Reset in RESP discards the pending response. Both return to IDLE with reset values.
- Reset has priority over every other event in the same cycle.

Optional Feature:
- Macro: DMEM_ERRCNT_EN.
- Defined: err_count increments by 1 on each access edge whose resp_err is set, and saturates at 16'hFFFF. It clears only on reset.
- Not defined: err_count is tied to 16'h0000, with no counter flops.

Test Plan:
1. WAIT_CYCLES=0: store word 0xDEADBEEF at 0x10, then load word at 0x10 → resp_valid exactly 1 cycle after each acceptance, rdata=0xDEADBEEF, err=0.
2. Byte lanes: store byte 0xAA at 0x21, store half 0x8001 at 0x22, load word 0x20 → 0x8001AA00 (word previously 0). Then load half at 0x22 → 0xFFFF8001 signed, 0x00008001 unsigned. Load byte at 0x21 signed → 0xFFFFFFAA.
3. Faults: load half at 0x03, store word at 0x06, access at 0x200 (DEPTH=128) → each resp_err=1, rdata=0, RAM unchanged. With DMEM_ERRCNT_EN, err_count=3; without it, err_count=0.
4. WAIT_CYCLES=3 with resp_ready held 0 for 5 cycles → resp_valid asserts 4 cycles after acceptance and holds with stable data. req_ready stays 0 until the cycle after resp_ready=1.
5. WAIT_CYCLES=3: store 0x12345678 at 0x40, pulse reset 2 cycles after acceptance, then load word at 0x40 → prior contents returned (write aborted). Outputs equal reset values the cycle after reset.
6. Back-to-back loads with req_valid and resp_ready held at 1, WAIT_CYCLES=0 → one response every 2 cycles, in request order.
